// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage sitting directly upstream of execute.
//
// Fetched {PC, instruction} pairs arrive over a valid/ready handshake. Each one
// is decoded into RV32I fields and control flags, its operands are read from an
// internal register file, and everything is captured in a single output
// register that execute consumes. Writeback from execute returns through the
// i_WB_* port to update the register file. A same-cycle writeback to a source
// register is forwarded into the captured operand.
//
// Ports:
//   i_CLK, i_RST          clock (rising edge), synchronous active-high reset
//   i_FLUSH               drop the held and any incoming instruction
//   i_VALID / o_READY     fetch -> decode handshake (o_READY = !o_VALID | i_READY)
//   i_PC, i_INSTRUCTION   offered instruction
//   i_WB_RD/_RD_PTR/_REG_WE  register file write port from writeback
//   o_VALID / i_READY     decode -> execute handshake
//   o_PC, o_INSTRUCTION   registered copies of the loaded instruction
//   o_FUNCT3, o_FUNCT7, o_RD_PTR, o_RS1, o_RS2, o_IMM_VAL  decoded fields/operands
//   o_REG_WE .. o_AUIPC   control flags, o_ILLEGAL unsupported encoding
//
// Build option: define DECODE_RV32E_EN for a 16-entry register file. Register
// fields with bit 4 set that the format actually uses then flag the
// instruction illegal, and writebacks to x16..x31 are ignored.

module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_FLUSH,
    input  logic        i_VALID,
    output logic        o_READY,
    input  logic [31:0] i_PC,
    input  logic [31:0] i_INSTRUCTION,
    input  logic [31:0] i_WB_RD,
    input  logic [4:0]  i_WB_RD_PTR,
    input  logic        i_WB_REG_WE,
    output logic        o_VALID,
    input  logic        i_READY,
    output logic [31:0] o_PC,
    output logic [31:0] o_INSTRUCTION,
    output logic [2:0]  o_FUNCT3,
    output logic [6:0]  o_FUNCT7,
    output logic [4:0]  o_RD_PTR,
    output logic [31:0] o_RS1,
    output logic [31:0] o_RS2,
    output logic [31:0] o_IMM_VAL,
    output logic        o_REG_WE,
    output logic        o_MEM_WE,
    output logic        o_MEM_RE,
    output logic        o_ECALL,
    output logic        o_IMM,
    output logic        o_JAL,
    output logic        o_LUI,
    output logic        o_AUIPC,
    output logic        o_ILLEGAL
);

`ifdef DECODE_RV32E_EN
    localparam int NR = 16;
`else
    localparam int NR = NREGS;
`endif
    localparam int            AW  = $clog2(NR);
    localparam logic [5:0]    NR6 = 6'(NR);

    logic [31:0] rf [NR];

    // Output register (stage p1)
    logic        vld_p1;
    logic [31:0] pc_p1, instr_p1, rs1_p1, rs2_p1, imm_val_p1;
    logic [2:0]  funct3_p1;
    logic [6:0]  funct7_p1;
    logic [4:0]  rd_ptr_p1;
    logic [8:0]  flags_p1;   // {reg_we, mem_we, mem_re, ecall, imm, jal, lui, auipc, illegal}

    // Decode results for the offered instruction (stage p0)
    logic [6:0]  opcode_p0;
    logic [4:0]  rd_f_p0, rs1_f_p0, rs2_f_p0;
    logic [2:0]  funct3_p0;
    logic [6:0]  funct7_p0;
    logic [4:0]  rd_ptr_p0;
    logic [31:0] imm_val_p0, rs1_val_p0, rs2_val_p0;
    logic [8:0]  raw_flags_p0, flags_p0;
    logic        range_bad_p0;

    function automatic logic signed [31:0] sext12(input logic signed [11:0] v);
        return 32'(v);
    endfunction

    function automatic logic in_rf(input logic [4:0] idx);
        return ({1'b0, idx} < NR6);
    endfunction

    // x0 and entries outside the file read as zero; a same-cycle writeback wins.
    function automatic logic [31:0] read_rf(input logic [4:0] idx);
        if (idx == 5'd0 || !in_rf(idx))
            return 32'd0;
        else if (i_WB_REG_WE && i_WB_RD_PTR == idx)
            return i_WB_RD;
        else
            return rf[idx[AW-1:0]];
    endfunction

    always_ff @(posedge i_CLK) begin
        if (i_WB_REG_WE && i_WB_RD_PTR != 5'd0 && in_rf(i_WB_RD_PTR))
            rf[i_WB_RD_PTR[AW-1:0]] <= i_WB_RD;
    end

    assign opcode_p0  = i_INSTRUCTION[6:0];
    assign rd_f_p0    = i_INSTRUCTION[11:7];
    assign rs1_f_p0   = i_INSTRUCTION[19:15];
    assign rs2_f_p0   = i_INSTRUCTION[24:20];
    assign rs1_val_p0 = read_rf(rs1_f_p0);
    assign rs2_val_p0 = read_rf(rs2_f_p0);

    always_comb begin
        funct3_p0    = i_INSTRUCTION[14:12];
        funct7_p0    = 7'd0;
        rd_ptr_p0    = rd_f_p0;
        imm_val_p0   = 32'd0;
        raw_flags_p0 = 9'd0;
        unique case (opcode_p0)
            7'b0110011: begin
                raw_flags_p0 = 9'b1_0000_0000;
                funct7_p0    = i_INSTRUCTION[31:25];
            end
            7'b0010011: begin
                raw_flags_p0 = 9'b1_0001_0000;
                imm_val_p0   = sext12(i_INSTRUCTION[31:20]);
                // Only the shift-right immediates carry a meaningful funct7.
                if (i_INSTRUCTION[14:12] == 3'b101)
                    funct7_p0 = i_INSTRUCTION[31:25];
            end
            7'b0000011: begin
                raw_flags_p0 = 9'b1_0101_0000;
                imm_val_p0   = sext12(i_INSTRUCTION[31:20]);
            end
            7'b0100011: begin
                raw_flags_p0 = 9'b0_1001_0000;
                imm_val_p0   = sext12({i_INSTRUCTION[31:25], i_INSTRUCTION[11:7]});
                rd_ptr_p0    = 5'd0;
            end
            7'b0110111: begin
                raw_flags_p0 = 9'b1_0001_0100;
                imm_val_p0   = {i_INSTRUCTION[31:12], 12'd0};
                funct3_p0    = 3'd0;
            end
            7'b0010111: begin
                raw_flags_p0 = 9'b1_0001_0010;
                imm_val_p0   = {i_INSTRUCTION[31:12], 12'd0};
                funct3_p0    = 3'd0;
            end
            7'b1101111: begin
                // Execute adds this to PC to form the link value.
                raw_flags_p0 = 9'b1_0001_1000;
                imm_val_p0   = 32'd4;
                funct3_p0    = 3'd0;
            end
            7'b1110011: begin
                raw_flags_p0 = {(rd_f_p0 != 5'd0), 8'b0010_0000};
                imm_val_p0   = {20'd0, i_INSTRUCTION[31:20]};
            end
            default: raw_flags_p0 = 9'b0_0000_0001;
        endcase
    end

`ifdef DECODE_RV32E_EN
    // Only register fields that the format actually uses are range checked.
    always_comb begin
        unique case (opcode_p0)
            7'b0110011:             range_bad_p0 = rd_f_p0[4] | rs1_f_p0[4] | rs2_f_p0[4];
            7'b0010011, 7'b0000011,
            7'b1110011:             range_bad_p0 = rd_f_p0[4] | rs1_f_p0[4];
            7'b0100011:             range_bad_p0 = rs1_f_p0[4] | rs2_f_p0[4];
            7'b0110111, 7'b0010111,
            7'b1101111:             range_bad_p0 = rd_f_p0[4];
            default:                range_bad_p0 = 1'b0;
        endcase
    end
`else
    assign range_bad_p0 = 1'b0;
`endif

    assign flags_p0 = range_bad_p0 ? 9'b0_0000_0001 : raw_flags_p0;

    assign o_READY = !vld_p1 | i_READY;

    // p0 -> p1 boundary: reset beats flush, flush beats load.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            vld_p1     <= 1'b0;
            pc_p1      <= RESET_PC;
            instr_p1   <= 32'd0;
            funct3_p1  <= 3'd0;
            funct7_p1  <= 7'd0;
            rd_ptr_p1  <= 5'd0;
            rs1_p1     <= 32'd0;
            rs2_p1     <= 32'd0;
            imm_val_p1 <= 32'd0;
            flags_p1   <= 9'd0;
        end else if (i_FLUSH) begin
            vld_p1 <= 1'b0;
        end else if (o_READY) begin
            vld_p1 <= i_VALID;
            if (i_VALID) begin
                pc_p1      <= i_PC;
                instr_p1   <= i_INSTRUCTION;
                funct3_p1  <= funct3_p0;
                funct7_p1  <= funct7_p0;
                rd_ptr_p1  <= rd_ptr_p0;
                rs1_p1     <= rs1_val_p0;
                rs2_p1     <= rs2_val_p0;
                imm_val_p1 <= imm_val_p0;
                flags_p1   <= flags_p0;
            end
        end
    end

    assign o_VALID       = vld_p1;
    assign o_PC          = pc_p1;
    assign o_INSTRUCTION = instr_p1;
    assign o_FUNCT3      = funct3_p1;
    assign o_FUNCT7      = funct7_p1;
    assign o_RD_PTR      = rd_ptr_p1;
    assign o_RS1         = rs1_p1;
    assign o_RS2         = rs2_p1;
    assign o_IMM_VAL     = imm_val_p1;
    assign {o_REG_WE, o_MEM_WE, o_MEM_RE, o_ECALL, o_IMM,
            o_JAL, o_LUI, o_AUIPC, o_ILLEGAL} = flags_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected results are queued when an
// instruction is offered and compared when the output register presents it.

module tb_decode_stage;

    localparam logic [8:0] F_REG = 9'h100, F_MW = 9'h080, F_MR = 9'h040, F_EC = 9'h020,
                           F_IM  = 9'h010, F_JAL = 9'h008, F_LUI = 9'h004, F_AUI = 9'h002,
                           F_ILL = 9'h001;

    typedef struct {
        logic [31:0] pc, instr, rs1, rs2, imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        chk_f7;
        logic [4:0]  rd;
        logic [8:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, wb_we;
    logic [31:0] in_pc, in_instr, wb_data;
    logic [4:0]  wb_ptr;
    logic        o_ready, o_valid;
    logic [31:0] o_pc, o_instr, o_rs1, o_rs2, o_imm_val;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [4:0]  o_rd_ptr;
    logic        o_reg_we, o_mem_we, o_mem_re, o_ecall, o_imm, o_jal, o_lui, o_auipc, o_illegal;
    logic [8:0]  obs_flags;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [31:0] rm [32];

    always #5 clk = ~clk;

    assign obs_flags = {o_reg_we, o_mem_we, o_mem_re, o_ecall, o_imm, o_jal, o_lui, o_auipc, o_illegal};

    decode_stage dut (
        .i_CLK(clk), .i_RST(rst), .i_FLUSH(flush), .i_VALID(in_valid), .o_READY(o_ready),
        .i_PC(in_pc), .i_INSTRUCTION(in_instr), .i_WB_RD(wb_data), .i_WB_RD_PTR(wb_ptr),
        .i_WB_REG_WE(wb_we), .o_VALID(o_valid), .i_READY(in_ready), .o_PC(o_pc),
        .o_INSTRUCTION(o_instr), .o_FUNCT3(o_funct3), .o_FUNCT7(o_funct7), .o_RD_PTR(o_rd_ptr),
        .o_RS1(o_rs1), .o_RS2(o_rs2), .o_IMM_VAL(o_imm_val), .o_REG_WE(o_reg_we),
        .o_MEM_WE(o_mem_we), .o_MEM_RE(o_mem_re), .o_ECALL(o_ecall), .o_IMM(o_imm),
        .o_JAL(o_jal), .o_LUI(o_lui), .o_AUIPC(o_auipc), .o_ILLEGAL(o_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [4:0] rd, input logic [2:0] f3,
                                input logic [6:0] f7, input logic chk_f7,
                                input logic [31:0] imm, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [8:0] flags);
        exp_t e;
        e.pc = pc; e.instr = instr; e.rd = rd; e.f3 = f3; e.f7 = f7; e.chk_f7 = chk_f7;
        e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.flags = flags;
        return e;
    endfunction

    // Offer one instruction for exactly one edge (i_READY must allow the load).
    task automatic send(input logic [31:0] pc, input logic [31:0] instr, input exp_t e);
        in_pc = pc; in_instr = instr; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("valid", 32'(o_valid), 32'd1);
            chk("pc", o_pc, e.pc);
            chk("instr", o_instr, e.instr);
            chk("rd_ptr", 32'(o_rd_ptr), 32'(e.rd));
            chk("funct3", 32'(o_funct3), 32'(e.f3));
            if (e.chk_f7) chk("funct7", 32'(o_funct7), 32'(e.f7));
            chk("imm_val", o_imm_val, e.imm);
            chk("rs1", o_rs1, e.rs1);
            chk("rs2", o_rs2, e.rs2);
            chk("flags", 32'(obs_flags), 32'(e.flags));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b1; wb_we = 1'b0;
        in_pc = 32'd0; in_instr = 32'd0; wb_data = 32'd0; wb_ptr = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_pc", o_pc, 32'h0000_0000);
        chk("rst_flags", 32'(obs_flags), 32'd0);
        chk("rst_imm", o_imm_val, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);

        // Preload the register file through the writeback port.
        rm[0] = 32'd0;
        for (int k = 1; k < 32; k++) begin
`ifdef DECODE_RV32E_EN
            rm[k] = (k >= 16) ? 32'd0 : 32'h1000_0000 + k * 32'h0101;
`else
            rm[k] = 32'h1000_0000 + k * 32'h0101;
`endif
            wb_we = 1'b1; wb_ptr = 5'(k); wb_data = 32'h1000_0000 + k * 32'h0101;
            @(posedge clk); #1;
        end
        wb_we = 1'b0;

        // ADDI x1,x0,5
        send(32'h0, 32'h0050_0093, mk(32'h0, 32'h0050_0093, 5'd1, 3'd0, 7'd0, 1'b1,
                                      32'd5, 32'd0, rm[5], F_REG | F_IM));
        expect_out();
        @(negedge clk);
        chk("idle_clears_valid", 32'(o_valid), 32'd0);

        // ADD x4,x0,x0 while writing x0: x0 must stay zero and never bypass.
        wb_we = 1'b1; wb_ptr = 5'd0; wb_data = 32'h0000_0055;
        send(32'h4, 32'h0000_0233, mk(32'h4, 32'h0000_0233, 5'd4, 3'd0, 7'd0, 1'b1,
                                      32'd0, 32'd0, 32'd0, F_REG));
        wb_we = 1'b0;
        expect_out();

        // ADD x3,x2,x2 with a same-cycle writeback of x2.
        wb_we = 1'b1; wb_ptr = 5'd2; wb_data = 32'hDEAD_BEEF;
        send(32'h8, 32'h0021_01B3, mk(32'h8, 32'h0021_01B3, 5'd3, 3'd0, 7'd0, 1'b1,
                                      32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, F_REG));
        wb_we = 1'b0;
        rm[2] = 32'hDEAD_BEEF;
        expect_out();

        // LW x5,-4(x2), then stall execute for three cycles with SW pending.
        send(32'hC, 32'hFFC1_2283, mk(32'hC, 32'hFFC1_2283, 5'd5, 3'd2, 7'd0, 1'b0,
                                      32'hFFFF_FFFC, rm[2], rm[28], F_REG | F_MR | F_IM));
        in_ready = 1'b0;
        in_pc = 32'h10; in_instr = 32'h0030_A423; in_valid = 1'b1;
        expect_out();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_ready", 32'(o_ready), 32'd0);
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_pc", o_pc, 32'hC);
            chk("hold_imm", o_imm_val, 32'hFFFF_FFFC);
            chk("hold_flags", 32'(obs_flags), 32'(F_REG | F_MR | F_IM));
        end
        in_ready = 1'b1;
        sb.push_back(mk(32'h10, 32'h0030_A423, 5'd0, 3'd2, 7'd0, 1'b0,
                        32'd8, rm[1], rm[3], F_MW | F_IM));
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_out();

        // JAL x1 at PC 0x100
        send(32'h100, 32'h0100_00EF, mk(32'h100, 32'h0100_00EF, 5'd1, 3'd0, 7'd0, 1'b1,
                                        32'd4, 32'd0, rm[16], F_REG | F_IM | F_JAL));
        expect_out();

        // Flush together with an offered instruction drops it.
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h104; in_instr = 32'h0050_0093;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_ready", 32'(o_ready), 32'd1);

        // SRAI x1,x1,3
        send(32'h104, 32'h4030_D093, mk(32'h104, 32'h4030_D093, 5'd1, 3'd5, 7'h20, 1'b1,
                                        32'h403, rm[1], rm[3], F_REG | F_IM));
        expect_out();

        // Unsupported opcode 0x7F
        send(32'h108, 32'h0000_007F, mk(32'h108, 32'h0000_007F, 5'd0, 3'd0, 7'd0, 1'b0,
                                        32'd0, 32'd0, 32'd0, F_ILL));
        expect_out();

        // LUI x5,0x12345
        send(32'h10C, 32'h1234_52B7, mk(32'h10C, 32'h1234_52B7, 5'd5, 3'd0, 7'd0, 1'b1,
                                        32'h1234_5000, rm[8], rm[3], F_REG | F_IM | F_LUI));
        expect_out();

        // ECALL (rd=0) and CSRRS x6,0xC00,x0 (zero-extended CSR number)
        send(32'h110, 32'h0000_0073, mk(32'h110, 32'h0000_0073, 5'd0, 3'd0, 7'd0, 1'b0,
                                        32'd0, 32'd0, 32'd0, F_EC));
        expect_out();
        send(32'h114, 32'hC000_2373, mk(32'h114, 32'hC000_2373, 5'd6, 3'd2, 7'd0, 1'b0,
                                        32'h0000_0C00, 32'd0, 32'd0, F_REG | F_EC));
        expect_out();

        // AUIPC x7,0xFFFFF
        send(32'h118, 32'hFFFF_F397, mk(32'h118, 32'hFFFF_F397, 5'd7, 3'd0, 7'd0, 1'b1,
                                        32'hFFFF_F000, rm[31], rm[31], F_REG | F_IM | F_AUI));
        expect_out();

        // ADD x17,x1,x1: legal with 32 registers, illegal with 16.
`ifdef DECODE_RV32E_EN
        e = mk(32'h11C, 32'h0010_88B3, 5'd17, 3'd0, 7'd0, 1'b1, 32'd0, rm[1], rm[1], F_ILL);
`else
        e = mk(32'h11C, 32'h0010_88B3, 5'd17, 3'd0, 7'd0, 1'b1, 32'd0, rm[1], rm[1], F_REG);
`endif
        send(32'h11C, 32'h0010_88B3, e);
        expect_out();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
